ln_vector_serializer: RTL and testbench
=======================================

Name: ln_vector_serializer

Overview:
- Receiving end of the layer_norm output interface.
- Captures each packed DIM-element Q8.8 result vector on a single-cycle valid pulse (layer_norm's valid_out / y_out).
- Buffers up to DEPTH vectors and streams them one element per beat over a valid/ready handshake toward downstream projection/writeback logic.
- layer_norm has no backpressure, so this block owns buffering and drop/overflow reporting.

Parameters:
- DIM, 4: elements per vector.
- DATA_WIDTH, 16: bits per element (Q8.8 signed, passed through unmodified).
- DEPTH, 2: vector slots in the internal FIFO. Power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- vec_valid  input  1  single-cycle pulse; vec_in is valid this cycle.
- vec_in  input  DIM*DATA_WIDTH  packed vector; element i = vec_in[i*DATA_WIDTH +: DATA_WIDTH].
- vec_ready  output  1  a slot is free this cycle (combinational).
- elem_valid  output  1  elem_data holds a valid element.
- elem_data  output  DATA_WIDTH  current element.
- elem_idx  output  $clog2(DIM)  index of the current element within its vector.
- elem_last  output  1  high with elem_valid when elem_idx == DIM-1.
- elem_ready  input  1  downstream accepts the element.
- clr_overflow  input  1  synchronous clear of the overflow flag.
- overflow  output  1  sticky: at least one vector was dropped.
- busy  output  1  FIFO non-empty.

Behaviour:
- Reset (async, rst_n low): wr_ptr, rd_ptr, count and elem_cnt = 0; FSM = IDLE; elem_valid, elem_last, overflow, busy = 0; elem_data, elem_idx = 0. Slot contents are don't-care.
- Reset mid-stream discards all buffered vectors. No partial vector is emitted after release.
- Beat transfer: elem_valid & elem_ready on a rising edge.
- Push:
  - vec_valid & vec_ready writes vec_in to slot wr_ptr; wr_ptr increments mod DEPTH.
  - vec_ready = (count < DEPTH) | pop_vec, where pop_vec = the last-element beat transfers this cycle.
  - Push while full is therefore accepted only when it coincides with the final-element pop.
- Drop: vec_valid & ~vec_ready discards the vector; FIFO state is unchanged; overflow <= 1 next cycle.
- Overflow flag:
  - Only reset or clr_overflow clears it.
  - clr_overflow and a drop in the same cycle leave overflow = 1 (set wins).
- FSM:
  - IDLE: elem_valid = 0. On count becoming nonzero go to STREAM; elem_valid rises the cycle after the push edge.
  - Latency: vec_valid at edge N puts element 0 on the outputs after edge N, visible for sampling at edge N+1.
  - STREAM: elem_valid = 1; elem_data = slot[rd_ptr] element elem_cnt; elem_idx = elem_cnt.
  - On each beat elem_cnt increments. elem_data is registered or mux-from-registered; outputs must be stable while elem_valid & ~elem_ready.
  - Beat with elem_last: elem_cnt <= 0; rd_ptr increments mod DEPTH; count decrements (unless a simultaneous push).
  - After that beat, if count (post-update) > 0, stay in STREAM with no bubble. Otherwise return to IDLE with elem_valid = 0 next cycle.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Element order: index 0 first. Data is not altered (no saturation or rounding).
- busy = (count != 0), registered alongside count.
- Throughput: one element per cycle with elem_ready held high. Sustained input rate is therefore at most one vector per DIM cycles without drops.

Decomposition:
- Shared package (transformer_pkg) holds:
  - Q8.8 constants: Q_FRAC = 8, Q_ONE = 16'sd256.
  - Default DIM / DATA_WIDTH localparams shared with layer_norm.
  - Element typedef q8_8_t.
- One natural sub-module: vec_fifo (DEPTH x DIM*DATA_WIDTH storage, pointers, count, full/empty, async active-low reset).
- ln_vector_serializer owns the FSM, element counter, output mux and overflow logic.

Test Plan:
- Single vector, elem_ready=1: push {16'sd1024,16'sd768,16'sd512,16'sd256} at edge N.
  - Beats at edges N+1..N+4 carry 0x0100, 0x0200, 0x0300, 0x0400 with idx 0..3; elem_last only on 0x0400.
  - elem_valid and busy are 0 afterwards; overflow stays 0.
- Backpressure: elem_ready low for 5 cycles after element 1 (0x0200).
  - elem_data and elem_idx hold at 0x0200 / 1 throughout; no skipped or duplicated element.
- Back-to-back: push vectors A = all 0x0200 and B = all 0x0080 four cycles apart.
  - Eight consecutive beats, A then B, with no bubble between A's last and B's element 0.
- Overflow: elem_ready=0; push three vectors on consecutive cycles with DEPTH=2.
  - Third is dropped and overflow=1; the first two stream intact when elem_ready goes high.
  - clr_overflow then clears it to 0.
- Push-at-full coincident with last pop: FIFO full, elem_ready=1; pulse vec_valid in the cycle elem_last transfers.
  - vec_ready=1, the vector is accepted, overflow stays 0, and all 3 vectors emerge in order.
- Async reset mid-stream: assert rst_n=0 between clock edges after element 2 of 4.
  - elem_valid, busy, overflow = 0 immediately.
  - After release, a fresh push streams from idx 0 with no stale data.

Source files
------------

// File: rtl/transformer_pkg.sv
// Definitions shared between layer_norm and its output serializer:
// Q8.8 constants, default vector geometry and the serializer state encoding.
package transformer_pkg;

    localparam int Q_FRAC = 8;
    localparam logic signed [15:0] Q_ONE = 16'sd256;

    localparam int LN_DIM        = 4;
    localparam int LN_DATA_WIDTH = 16;

    typedef logic signed [LN_DATA_WIDTH-1:0] q8_8_t;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ln_vector_serializer_vec_fifo.sv
// Vector-wide FIFO: DEPTH slots of WIDTH bits, registered count and non-empty flag.
// The caller decides acceptance; push/pop here are already qualified.
module vec_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             nonempty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign pop_en  = pop & nonempty;
    // A push into a full FIFO is legal only when the head slot is leaving.
    assign push_en = push & (~full | pop_en);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push_en, pop_en})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            nonempty <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_d;
            nonempty <= (count_d != '0);
        end
    end

    // Slot contents need no reset; they are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ln_vector_serializer.sv
// Buffers layer_norm result vectors and streams them one element per beat,
// reporting vectors dropped because no slot was free.
module ln_vector_serializer
    import transformer_pkg::*;
#(
    parameter int DIM        = LN_DIM,
    parameter int DATA_WIDTH = LN_DATA_WIDTH,
    parameter int DEPTH      = 2,
    localparam int IDX_W     = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vec_valid,
    input  logic [DIM*DATA_WIDTH-1:0] vec_in,
    output logic                      vec_ready,
    output logic                      elem_valid,
    output logic [DATA_WIDTH-1:0]     elem_data,
    output logic [IDX_W-1:0]          elem_idx,
    output logic                      elem_last,
    input  logic                      elem_ready,
    input  logic                      clr_overflow,
    output logic                      overflow,
    output logic                      busy
);

    // Handshakes: an element beat transfers on a rising edge where
    // elem_valid & elem_ready; elem_* hold steady while elem_valid & ~elem_ready.
    // A vector is taken on vec_valid & vec_ready; vec_valid & ~vec_ready drops it.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    ser_state_t                state;
    ser_state_t                state_d;
    logic [IDX_W-1:0]          elem_cnt;
    logic [DIM*DATA_WIDTH-1:0] head_vec;
    logic [DATA_WIDTH-1:0]     head_elems [DIM];
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      beat;
    logic                      pop_vec;
    logic                      push_vec;
    logic                      drop;

    vec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DIM * DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_vec),
        .push_data (vec_in),
        .pop       (pop_vec),
        .rd_data   (head_vec),
        .count     (count),
        .full      (full),
        .nonempty  (busy)
    );

    assign beat      = elem_valid & elem_ready;
    assign pop_vec   = beat & elem_last;
    assign vec_ready = ~full | pop_vec;
    assign push_vec  = vec_valid & vec_ready;
    assign drop      = vec_valid & ~vec_ready;

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            head_elems[i] = head_vec[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SER_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            SER_IDLE: begin
                // Leaving on the push itself makes element 0 visible right after the push edge.
                if (push_vec || busy) state_d = SER_STREAM;
            end
            SER_STREAM: begin
                if (pop_vec && (count == CNT_W'(1)) && !push_vec) state_d = SER_IDLE;
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
        end else if (beat) begin
            elem_cnt <= elem_last ? '0 : elem_cnt + IDX_W'(1);
        end
    end

    assign elem_valid = (state == SER_STREAM);
    assign elem_idx   = elem_cnt;
    assign elem_last  = elem_valid && (elem_cnt == LAST_IDX);
    assign elem_data  = elem_valid ? head_elems[elem_cnt] : '0;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ln_vector_serializer.sv
// Directed bench for ln_vector_serializer: expected beats are queued as vectors
// are pushed and a negedge monitor pops and compares each transferred element.
module tb_ln_vector_serializer;

    localparam int DIM   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int IDX_W = 2;
    localparam int EXP_W = DW + IDX_W + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                vec_valid = 1'b0;
    logic [DIM*DW-1:0]   vec_in = '0;
    logic                vec_ready;
    logic                elem_valid;
    logic [DW-1:0]       elem_data;
    logic [IDX_W-1:0]    elem_idx;
    logic                elem_last;
    logic                elem_ready = 1'b0;
    logic                clr_overflow = 1'b0;
    logic                overflow;
    logic                busy;

    logic [EXP_W-1:0]    exp_q[$];
    logic [EXP_W-1:0]    mon_exp;
    int                  n_vec = 0;
    int                  n_miss = 0;

    ln_vector_serializer #(
        .DIM        (DIM),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vec_valid    (vec_valid),
        .vec_in       (vec_in),
        .vec_ready    (vec_ready),
        .elem_valid   (elem_valid),
        .elem_data    (elem_data),
        .elem_idx     (elem_idx),
        .elem_last    (elem_last),
        .elem_ready   (elem_ready),
        .clr_overflow (clr_overflow),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the first n elements of v as expected beats, index 0 first.
    task automatic expect_vec(input logic [DIM*DW-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == DIM - 1) ? 1'b1 : 1'b0, IDX_W'(i), v[i*DW +: DW]});
        end
    endtask

    task automatic push_vec(input logic [DIM*DW-1:0] v, input int n_exp);
        vec_valid = 1'b1;
        vec_in    = v;
        expect_vec(v, n_exp);
        step();
        vec_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && !elem_valid && !busy) done = 1'b1;
            else step();
        end
        check(name, 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && elem_valid && elem_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_beat: got data 0x%0h idx %0d, no beat expected", elem_data, elem_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat", 32'({elem_last, elem_idx, elem_data}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_elem_valid", 32'(elem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_elem_data", 32'(elem_data), 32'd0);
        check("rst_elem_idx", 32'(elem_idx), 32'd0);
        check("rst_elem_last", 32'(elem_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_vec_ready", 32'(vec_ready), 32'd1);

        // Single vector, hand-computed beats
        elem_ready = 1'b1;
        vec_valid  = 1'b1;
        vec_in     = {16'sd1024, 16'sd768, 16'sd512, 16'sd256};
        exp_q.push_back({1'b0, 2'd0, 16'h0100});
        exp_q.push_back({1'b0, 2'd1, 16'h0200});
        exp_q.push_back({1'b0, 2'd2, 16'h0300});
        exp_q.push_back({1'b1, 2'd3, 16'h0400});
        step();
        vec_valid = 1'b0;
        check("single_first_valid", 32'(elem_valid), 32'd1);
        check("single_first_data", 32'(elem_data), 32'h0100);
        wait_drain("single_drain");
        check("single_idle_valid", 32'(elem_valid), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_overflow", 32'(overflow), 32'd0);

        // Backpressure on element 1
        push_vec({16'h0400, 16'h0300, 16'h0200, 16'h0100}, DIM);
        step();
        elem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_data", 32'(elem_data), 32'h0200);
            check("stall_idx", 32'(elem_idx), 32'd1);
            check("stall_valid", 32'(elem_valid), 32'd1);
        end
        elem_ready = 1'b1;
        wait_drain("stall_drain");

        // Back-to-back vectors, no bubble between them
        push_vec({4{16'h0200}}, DIM);
        for (int i = 0; i < 8; i++) begin
            check("b2b_no_bubble", 32'(elem_valid), 32'd1);
            if (i == 3) begin
                vec_valid = 1'b1;
                vec_in    = {4{16'h0080}};
                expect_vec({4{16'h0080}}, DIM);
            end else begin
                vec_valid = 1'b0;
            end
            step();
        end
        vec_valid = 1'b0;
        check("b2b_end_valid", 32'(elem_valid), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Overflow: third vector dropped while stalled
        elem_ready = 1'b0;
        push_vec({16'h0013, 16'h0012, 16'h0011, 16'h0010}, DIM);
        push_vec({16'h0023, 16'h0022, 16'h0021, 16'h0020}, DIM);
        check("ovf_full_not_ready", 32'(vec_ready), 32'd0);
        push_vec({16'h0033, 16'h0032, 16'h0031, 16'h0030}, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        elem_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Clear coinciding with a drop: set wins
        elem_ready = 1'b0;
        push_vec({16'h0043, 16'h0042, 16'h0041, 16'h0040}, DIM);
        push_vec({16'h0053, 16'h0052, 16'h0051, 16'h0050}, DIM);
        clr_overflow = 1'b1;
        push_vec({16'h0063, 16'h0062, 16'h0061, 16'h0060}, 0);
        clr_overflow = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        elem_ready = 1'b1;
        wait_drain("ovf2_drain");
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf2_cleared", 32'(overflow), 32'd0);

        // Push at full accepted together with the last-element pop
        elem_ready = 1'b0;
        push_vec({16'h0073, 16'h0072, 16'h0071, 16'h0070}, DIM);
        push_vec({16'h0083, 16'h0082, 16'h0081, 16'h0080}, DIM);
        elem_ready = 1'b1;
        step();
        step();
        step();
        check("full_pop_last", 32'(elem_last), 32'd1);
        check("full_pop_ready", 32'(vec_ready), 32'd1);
        push_vec({16'hFF00, 16'h8000, 16'h7FFF, 16'hFFFF}, DIM);
        check("full_pop_no_ovf", 32'(overflow), 32'd0);
        wait_drain("full_pop_drain");

        // Async reset mid-stream, with a buffered vector and overflow pending
        elem_ready = 1'b0;
        push_vec({16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 3);
        push_vec({16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0}, 0);
        push_vec({16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0}, 0);
        check("rstm_ovf_before", 32'(overflow), 32'd1);
        elem_ready = 1'b1;
        step();
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("rstm_valid", 32'(elem_valid), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_overflow", 32'(overflow), 32'd0);
        check("rstm_queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rstm_post_valid", 32'(elem_valid), 32'd0);
        check("rstm_post_busy", 32'(busy), 32'd0);
        push_vec({16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0}, DIM);
        check("rstm_fresh_idx", 32'(elem_idx), 32'd0);
        check("rstm_fresh_data", 32'(elem_data), 32'h00D0);
        wait_drain("rstm_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
